// File: rtl/apb4_slave_regbank_pkg.sv
// Shared types for the APB4 register bank.
//   apb_state_e  : transfer FSM states
//   err_cause_e  : reason a transfer was answered with PSLVERR
//   calc_al      : number of byte-address bits below the word index
package apb4_slave_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } apb_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_RANGE,
    ERR_MISALIGN,
    ERR_RO,
    ERR_PROT,
    ERR_STRB
  } err_cause_e;

  function automatic int calc_al(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb4_slave_regbank_if.sv
// APB4 bus bundle between a requester and the register bank.
//   master modport : drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT,
//                    receives PRDATA/PREADY/PSLVERR
//   slave modport  : the mirror image
interface apb4_slave_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [2:0]                PPROT;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_slave_regbank_decode.sv
// Combinational request decoder for the register bank.
//   i_addr  : byte address of the request
//   i_write : 1 write / 0 read
//   i_strb  : byte strobes
//   i_priv  : PPROT[0] (privileged access)
//   o_idx   : word index (address with the byte-offset bits dropped)
//   o_ro    : index falls in the read-only status window
//   o_err   : request must be answered with PSLVERR
module apb4_slave_regbank_decode
  import apb4_slave_regbank_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int RO_WORDS   = 2,
  parameter int PROT_CHECK = 1
) (
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_write,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  input  logic                    i_priv,
  output logic [ADDR_WIDTH-1:0]   o_idx,
  output logic                    o_ro,
  output logic                    o_err
);

  localparam int AL = calc_al(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << AL) - 1);

  err_cause_e w_cause;

  always_comb begin
    o_idx   = i_addr >> AL;
    o_ro    = (32'(o_idx) >= 32'(DEPTH - RO_WORDS)) && (32'(o_idx) < 32'(DEPTH));
    w_cause = ERR_NONE;
    // First matching cause wins; all of them lead to the same bus response.
    if ((i_addr & ALIGN_MASK) != '0)
      w_cause = ERR_MISALIGN;
    else if (32'(o_idx) >= 32'(DEPTH))
      w_cause = ERR_RANGE;
    else if (i_write && o_ro)
      w_cause = ERR_RO;
    else if ((PROT_CHECK != 0) && i_write && !i_priv)
      w_cause = ERR_PROT;
    else if (!i_write && (i_strb != '0))
      w_cause = ERR_STRB;
    o_err = (w_cause != ERR_NONE);
  end

endmodule

// File: rtl/apb4_slave_regbank.sv
// APB4 completer holding a DEPTH-word register bank.
//   PCLK, PRESET : clock and synchronous active-high reset
//   apb          : APB4 bus (slave modport)
//   hw_status    : read-only status words, RO word k at bits [k*DW +: DW]
//   reg_q        : flattened R/W words, word 0 at the LSBs
// The top RO_WORDS indices read hw_status; the rest are R/W control words
// with per-byte strobes. Every transfer takes WAIT_CYCLES wait states and
// then one completing cycle in which PREADY/PRDATA/PSLVERR are valid.
module apb4_slave_regbank
  import apb4_slave_regbank_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int RO_WORDS    = 2,
  parameter int WAIT_CYCLES = 0,
  parameter int PROT_CHECK  = 1
) (
  input  logic                                  PCLK,
  input  logic                                  PRESET,
  apb4_slave_regbank_if.slave                   apb,
  input  logic [RO_WORDS*DATA_WIDTH-1:0]        hw_status,
  output logic [(DEPTH-RO_WORDS)*DATA_WIDTH-1:0] reg_q
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int NRW = DEPTH - RO_WORDS;

  apb_state_e              r_state;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [SW-1:0]           r_strb;
  logic                    r_priv;
  logic [DATA_WIDTH-1:0]   r_words [NRW];
  logic [DATA_WIDTH-1:0]   r_prdata;
  logic                    r_pready;
  logic                    r_pslverr;

  logic                    w_setup;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic                    w_write;
  logic [SW-1:0]           w_strb;
  logic                    w_priv;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_ro;
  logic                    w_err;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_unused_prot;

  assign w_setup       = apb.PSEL && !apb.PENABLE;
  // Only the privilege bit matters to this completer.
  assign w_unused_prot = ^apb.PPROT[2:1];

  // With no wait states the response is produced on the same edge the setup
  // is sampled, so the decoder sees the live bus in IDLE and the latched
  // request everywhere else.
  assign w_addr  = (r_state == IDLE) ? apb.PADDR       : r_addr;
  assign w_write = (r_state == IDLE) ? apb.PWRITE      : r_write;
  assign w_strb  = (r_state == IDLE) ? apb.PSTRB       : r_strb;
  assign w_priv  = (r_state == IDLE) ? apb.PPROT[0]    : r_priv;

  apb4_slave_regbank_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .RO_WORDS   (RO_WORDS),
    .PROT_CHECK (PROT_CHECK)
  ) u_decode (
    .i_addr  (w_addr),
    .i_write (w_write),
    .i_strb  (w_strb),
    .i_priv  (w_priv),
    .o_idx   (w_idx),
    .o_ro    (w_ro),
    .o_err   (w_err)
  );

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NRW; i++)
      if (!w_ro && (w_idx == ADDR_WIDTH'(i))) w_rdata = r_words[i];
    for (int k = 0; k < RO_WORDS; k++)
      if (w_ro && (w_idx == ADDR_WIDTH'(NRW + k)))
        w_rdata = hw_status[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Request capture at the setup edge
  always_ff @(posedge PCLK) begin
    if ((r_state == IDLE) && w_setup) begin
      r_addr  <= apb.PADDR;
      r_write <= apb.PWRITE;
      r_wdata <= apb.PWDATA;
      r_strb  <= apb.PSTRB;
      r_priv  <= apb.PPROT[0];
    end
  end

  // Transfer FSM, register bank and registered bus outputs
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      for (int i = 0; i < NRW; i++) r_words[i] <= '0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            if (WAIT_CYCLES == 0) begin
              r_state   <= DONE;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= (w_err || w_write) ? '0 : w_rdata;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (!apb.PSEL) begin
            r_state <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state   <= DONE;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= (w_err || w_write) ? '0 : w_rdata;
          end
        end
        DONE: begin
          r_state <= IDLE;
          if (w_write && !w_err) begin
            for (int i = 0; i < NRW; i++)
              if (w_idx == ADDR_WIDTH'(i))
                for (int b = 0; b < SW; b++)
                  if (r_strb[b]) r_words[i][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign apb.PRDATA  = r_prdata;
  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;

  for (genvar g = 0; g < NRW; g++) begin : g_flat
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_words[g];
  end

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Directed bench for apb4_slave_regbank: one instance with no wait states
// (bus0) and one with three wait states (bus3), driven from shared stimulus
// signals routed by 'sel'.
module tb_apb4_slave_regbank;

  logic PCLK = 1'b0;
  logic rst0, rst3, sel;
  logic       t_psel, t_penable, t_pwrite;
  logic [7:0] t_paddr;
  logic [31:0] t_pwdata;
  logic [3:0] t_pstrb;
  logic [2:0] t_pprot;

  localparam logic [63:0] HW = {32'hC3C3000F, 32'h5A5A0014};

  logic [447:0] reg_q0, reg_q3;
  logic [447:0] exp_q;
  logic         o_pready, o_pslverr;
  logic [31:0]  o_prdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb4_slave_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus0 ();
  apb4_slave_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus3 ();

  assign bus0.PSEL    = !sel && t_psel;
  assign bus0.PENABLE = !sel && t_penable;
  assign bus0.PWRITE  = t_pwrite;
  assign bus0.PADDR   = t_paddr;
  assign bus0.PWDATA  = t_pwdata;
  assign bus0.PSTRB   = t_pstrb;
  assign bus0.PPROT   = t_pprot;
  assign bus3.PSEL    = sel && t_psel;
  assign bus3.PENABLE = sel && t_penable;
  assign bus3.PWRITE  = t_pwrite;
  assign bus3.PADDR   = t_paddr;
  assign bus3.PWDATA  = t_pwdata;
  assign bus3.PSTRB   = t_pstrb;
  assign bus3.PPROT   = t_pprot;

  assign o_pready  = sel ? bus3.PREADY  : bus0.PREADY;
  assign o_pslverr = sel ? bus3.PSLVERR : bus0.PSLVERR;
  assign o_prdata  = sel ? bus3.PRDATA  : bus0.PRDATA;

  apb4_slave_regbank #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .RO_WORDS(2),
    .WAIT_CYCLES(0), .PROT_CHECK(1)
  ) u_dut0 (
    .PCLK(PCLK), .PRESET(rst0), .apb(bus0), .hw_status(HW), .reg_q(reg_q0)
  );

  apb4_slave_regbank #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .RO_WORDS(2),
    .WAIT_CYCLES(3), .PROT_CHECK(1)
  ) u_dut3 (
    .PCLK(PCLK), .PRESET(rst3), .apb(bus3), .hw_status(HW), .reg_q(reg_q3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge with the bus idle; returns at #1 after
  // the completing edge with PSEL low (same instant a next setup may start).
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er, output int wt);
    bit done;
    t_psel = 1'b1; t_penable = 1'b0; t_pwrite = wr;
    t_paddr = addr; t_pwdata = wd; t_pstrb = st; t_pprot = pr;
    @(posedge PCLK); #1;
    t_penable = 1'b1;
    wt = 0; rd = '0; er = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge PCLK);
      if (o_pready) begin
        rd = o_prdata; er = o_pslverr; done = 1'b1;
      end else begin
        wt++;
        if (wt > 20) done = 1'b1;
        else begin @(posedge PCLK); #1; end
      end
    end
    @(posedge PCLK); #1;
    t_psel = 1'b0; t_penable = 1'b0;
  endtask

  task automatic do_wr(input string tag, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr,
                       input logic exp_err, input int exp_wt);
    logic [31:0] rd; logic er; int wt;
    xfer(1'b1, addr, wd, st, pr, rd, er, wt);
    chk({tag, "_wait"}, 32'(wt), 32'(exp_wt));
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  task automatic do_rd(input string tag, input logic [7:0] addr, input logic [3:0] st,
                       input logic [31:0] exp_d, input logic exp_err, input int exp_wt);
    logic [31:0] rd; logic er; int wt;
    xfer(1'b0, addr, 32'h0, st, 3'b001, rd, er, wt);
    chk({tag, "_wait"}, 32'(wt), 32'(exp_wt));
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    chk({tag, "_data"}, rd, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst0 = 1'b1; rst3 = 1'b1;
    t_psel = 1'b0; t_penable = 1'b0; t_pwrite = 1'b0;
    t_paddr = '0; t_pwdata = '0; t_pstrb = '0; t_pprot = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready0", {31'b0, bus0.PREADY}, 32'h0);
    chk("rst_prdata0", bus0.PRDATA, 32'h0);
    chk("rst_pslverr0", {31'b0, bus0.PSLVERR}, 32'h0);
    chk_w("rst_regq0", reg_q0, '0);
    chk("rst_pready3", {31'b0, bus3.PREADY}, 32'h0);
    chk_w("rst_regq3", reg_q3, '0);
    @(posedge PCLK); #1;
    rst0 = 1'b0; rst3 = 1'b0;
    @(posedge PCLK); #1;

    // ---------- no wait states ----------
    do_wr("wr04", 8'h04, 32'hDEADBEEF, 4'hF, 3'b001, 1'b0, 0);
    chk("wr04_regq", reg_q0[1*32 +: 32], 32'hDEADBEEF);
    @(negedge PCLK);
    chk("pready_one_cycle", {31'b0, o_pready}, 32'h0);
    chk("prdata_idle", o_prdata, 32'h0);
    @(posedge PCLK); #1;
    do_rd("rd04", 8'h04, 4'h0, 32'hDEADBEEF, 1'b0, 0);

    do_wr("wr08_full", 8'h08, 32'hAABBCCDD, 4'hF, 3'b001, 1'b0, 0);
    do_wr("wr08_strb", 8'h08, 32'h11223344, 4'b0101, 3'b001, 1'b0, 0);
    do_rd("rd08", 8'h08, 4'h0, 32'hAA22CC44, 1'b0, 0);
    do_wr("wr08_nostrb", 8'h08, 32'hFFFFFFFF, 4'h0, 3'b001, 1'b0, 0);
    do_rd("rd08_again", 8'h08, 4'h0, 32'hAA22CC44, 1'b0, 0);
    do_rd("rd_ro14", 8'h38, 4'h0, 32'h5A5A0014, 1'b0, 0);
    do_rd("rd_ro15", 8'h3C, 4'h0, 32'hC3C3000F, 1'b0, 0);

    // ---------- error responses ----------
    exp_q = '0;
    exp_q[1*32 +: 32] = 32'hDEADBEEF;
    exp_q[2*32 +: 32] = 32'hAA22CC44;
    do_wr("err_wr40", 8'h40, 32'hFFFFFFFF, 4'hF, 3'b001, 1'b1, 0);
    chk_w("err_wr40_regq", reg_q0, exp_q);
    do_rd("err_rd40", 8'h40, 4'h0, 32'h0, 1'b1, 0);
    do_wr("err_wr02", 8'h02, 32'hFFFFFFFF, 4'hF, 3'b001, 1'b1, 0);
    chk_w("err_wr02_regq", reg_q0, exp_q);
    do_wr("err_wr_ro", 8'h38, 32'hFFFFFFFF, 4'hF, 3'b001, 1'b1, 0);
    chk_w("err_wr_ro_regq", reg_q0, exp_q);
    do_wr("err_prot", 8'h0C, 32'h12345678, 4'hF, 3'b000, 1'b1, 0);
    chk_w("err_prot_regq", reg_q0, exp_q);
    do_rd("err_rd_strb", 8'h04, 4'h1, 32'h0, 1'b1, 0);
    chk_w("err_rd_strb_regq", reg_q0, exp_q);

    // PENABLE without a preceding setup is ignored
    t_psel = 1'b1; t_penable = 1'b1; t_pwrite = 1'b1;
    t_paddr = 8'h0C; t_pwdata = 32'h99999999; t_pstrb = 4'hF; t_pprot = 3'b001;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("noset_pready", {31'b0, o_pready}, 32'h0);
    end
    @(posedge PCLK); #1;
    t_psel = 1'b0; t_penable = 1'b0;
    @(posedge PCLK); #1;
    chk_w("noset_regq", reg_q0, exp_q);

    // ---------- three wait states ----------
    sel = 1'b1;
    @(posedge PCLK); #1;
    do_wr("w3_wr10", 8'h10, 32'h0BADF00D, 4'hF, 3'b001, 1'b0, 3);
    chk("w3_wr10_regq", reg_q3[4*32 +: 32], 32'h0BADF00D);
    do_rd("w3_rd10", 8'h10, 4'h0, 32'h0BADF00D, 1'b0, 3);
    // back-to-back: second setup in the cycle right after completion
    do_rd("w3_b2b_a", 8'h10, 4'h0, 32'h0BADF00D, 1'b0, 3);
    do_rd("w3_b2b_b", 8'h38, 4'h0, 32'h5A5A0014, 1'b0, 3);
    do_rd("w3_err02", 8'h02, 4'h0, 32'h0, 1'b1, 3);

    // PSEL dropped during wait states: transfer abandoned
    t_psel = 1'b1; t_penable = 1'b0; t_pwrite = 1'b1;
    t_paddr = 8'h14; t_pwdata = 32'h77777777; t_pstrb = 4'hF; t_pprot = 3'b001;
    @(posedge PCLK); #1;
    t_penable = 1'b1;
    @(posedge PCLK); #1;
    t_psel = 1'b0; t_penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("psel_abort_pready", {31'b0, o_pready}, 32'h0);
    end
    chk("psel_abort_regq", reg_q3[5*32 +: 32], 32'h0);
    @(posedge PCLK); #1;

    // PRESET during wait states of a write to 0x0C
    t_psel = 1'b1; t_penable = 1'b0; t_pwrite = 1'b1;
    t_paddr = 8'h0C; t_pwdata = 32'h12345678; t_pstrb = 4'hF; t_pprot = 3'b001;
    @(posedge PCLK); #1;
    t_penable = 1'b1;
    @(posedge PCLK); #1;
    rst3 = 1'b1;
    @(negedge PCLK);
    chk("rst_abort_pready_a", {31'b0, o_pready}, 32'h0);
    @(posedge PCLK); #1;
    rst3 = 1'b0; t_psel = 1'b0; t_penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk("rst_abort_pready_b", {31'b0, o_pready}, 32'h0);
    end
    chk("rst_abort_word3", reg_q3[3*32 +: 32], 32'h0);
    @(posedge PCLK); #1;
    do_wr("post_rst_wr0c", 8'h0C, 32'h600DCAFE, 4'hF, 3'b001, 1'b0, 3);
    chk("post_rst_word3", reg_q3[3*32 +: 32], 32'h600DCAFE);
    do_rd("post_rst_rd0c", 8'h0C, 4'h0, 32'h600DCAFE, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
